// File: rtl/ascon_output_collector_pkg.sv
// Shared types and constants for the Ascon serial output collector.
// Holds the FSM encoding, default stream widths and width helpers.
package ascon_output_collector_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_e;

    localparam int DEF_DATA_W = 128;
    localparam int DEF_TAG_W  = 128;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ascon_rise_detect.sv
// Registered rising-edge detector: one-cycle pulse on a 0->1 transition of d.
module ascon_rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic d_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) d_q <= 1'b0;
        else      d_q <= d;
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/ascon_output_collector.sv
// Deserialises the Ascon core's serial data/tag streams into parallel words,
// presents them on valid/ready and checks the tag in decrypt mode.
module ascon_output_collector
    import ascon_output_collector_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int TAG_W  = DEF_TAG_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ser_data_i,
    input  logic              ser_tag_i,
    input  logic              core_ready_i,
    input  logic              decrypt_i,
    input  logic [TAG_W-1:0]  exp_tag_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [TAG_W-1:0]  out_tag_o,
    output logic              tag_ok_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              busy_o,
    output logic              overrun_o,
    input  logic              clr_ovr_i
);

    localparam int N     = max_int(DATA_W, TAG_W);
    localparam int CNT_W = clog2(N + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] DW_C = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] TW_C = CNT_W'(TAG_W);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, idx;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic               dec_q, dec_d, dec_eff;
    logic               valid_q, valid_d;
    logic               ok_q, ok_d;
    logic               ovr_q, ovr_d;
    logic               rise, start, cap, ovr_set;

    ascon_rise_detect u_ready_rise (
        .clk  (clk),
        .rst  (rst),
        .d    (core_ready_i),
        .rise (rise)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        tag_d   = tag_q;
        dec_d   = dec_q;
        valid_d = valid_q;
        ok_d    = ok_q;
        start   = 1'b0;
        cap     = 1'b0;
        ovr_set = 1'b0;

        case (state_q)
            IDLE:  start = rise;
            SHIFT: begin
                cap     = 1'b1;
                ovr_set = rise;
            end
            HOLD: begin
                if (out_ready_i) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                    start   = rise;
                end else begin
                    ovr_set = rise;
                end
            end
            default: state_d = IDLE;
        endcase

        // A start is simply a capture of bit index 0 with a freshly latched mode.
        idx     = start ? '0 : cnt_q;
        dec_eff = start ? decrypt_i : dec_q;
        if (start) dec_d = decrypt_i;

        if (start || cap) begin
            if (idx < DW_C) data_d = (data_q << 1) | DATA_W'(ser_data_i);
            if (idx < TW_C) tag_d  = (tag_q << 1) | TAG_W'(ser_tag_i);
            cnt_d = idx + 1'b1;
            if (idx == LAST) begin
                state_d = HOLD;
                valid_d = 1'b1;
                ok_d    = dec_eff ? (tag_d == exp_tag_i) : 1'b1;
            end else begin
                state_d = SHIFT;
            end
        end

        ovr_d = ovr_set ? 1'b1 : (clr_ovr_i ? 1'b0 : ovr_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            tag_q   <= '0;
            dec_q   <= 1'b0;
            valid_q <= 1'b0;
            ok_q    <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            tag_q   <= tag_d;
            dec_q   <= dec_d;
            valid_q <= valid_d;
            ok_q    <= ok_d;
            ovr_q   <= ovr_d;
        end
    end

    assign out_data_o  = data_q;
    assign out_tag_o   = tag_q;
    assign tag_ok_o    = ok_q;
    assign out_valid_o = valid_q;
    assign busy_o      = (state_q == SHIFT);
    assign overrun_o   = ovr_q;

endmodule

// File: tb/tb_ascon_output_collector.sv
// Directed plus randomized bench for ascon_output_collector (8/4 and 128/128 instances).
module tb_ascon_output_collector;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       ser_data = 0, ser_tag = 0, core_ready = 0, decrypt = 0;
    logic       out_ready = 0, clr_ovr = 0;
    logic [3:0] exp_tag = '0;
    logic [7:0] out_data;
    logic [3:0] out_tag;
    logic       tag_ok, out_valid, busy, overrun;

    logic         b_ser_data = 0, b_ser_tag = 0, b_core_ready = 0, b_decrypt = 0;
    logic         b_out_ready = 0, b_clr_ovr = 0;
    logic [127:0] b_exp_tag = '0;
    logic [127:0] b_out_data, b_out_tag;
    logic         b_tag_ok, b_out_valid, b_busy, b_overrun;

    int n_assert = 0;
    int n_fail   = 0;

    ascon_output_collector #(.DATA_W(8), .TAG_W(4)) dut (
        .clk(clk), .rst(rst), .ser_data_i(ser_data), .ser_tag_i(ser_tag),
        .core_ready_i(core_ready), .decrypt_i(decrypt), .exp_tag_i(exp_tag),
        .out_data_o(out_data), .out_tag_o(out_tag), .tag_ok_o(tag_ok),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .busy_o(busy),
        .overrun_o(overrun), .clr_ovr_i(clr_ovr)
    );

    ascon_output_collector #(.DATA_W(128), .TAG_W(128)) dut_wide (
        .clk(clk), .rst(rst), .ser_data_i(b_ser_data), .ser_tag_i(b_ser_tag),
        .core_ready_i(b_core_ready), .decrypt_i(b_decrypt), .exp_tag_i(b_exp_tag),
        .out_data_o(b_out_data), .out_tag_o(b_out_tag), .tag_ok_o(b_tag_ok),
        .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .busy_o(b_busy),
        .overrun_o(b_overrun), .clr_ovr_i(b_clr_ovr)
    );

    task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference rule: encrypt always passes, decrypt passes only on exact tag match.
    function automatic logic model_ok(input logic dec, input logic [3:0] t, input logic [3:0] e);
        return dec ? (t == e) : 1'b1;
    endfunction

    // Sends one word MSB-first starting with a ready rise; glitch>=0 drops core_ready
    // for that step so a second rise lands inside the capture.
    task automatic send(input logic [7:0] d, input logic [3:0] t, input logic dec, input int glitch);
        for (int i = 0; i < 8; i++) begin
            core_ready = !(glitch >= 0 && i == glitch);
            ser_data   = d[7-i];
            ser_tag    = (i < 4) ? t[3-i] : 1'($urandom);
            decrypt    = (i == 0) ? dec : 1'($urandom);
            step();
            if (i < 7) begin
                check("valid_low_in_shift", 128'(out_valid), 128'(1'b0));
                check("busy_in_shift", 128'(busy), 128'(1'b1));
            end
        end
        core_ready = 1'b0;
        ser_data   = 1'($urandom);
        ser_tag    = 1'($urandom);
        check("valid_at_cycle8", 128'(out_valid), 128'(1'b1));
        check("busy_in_hold", 128'(busy), 128'(1'b0));
        check("data_word", 128'(out_data), 128'(d));
        check("tag_word", 128'(out_tag), 128'(t));
    endtask

    initial begin
        logic [7:0]   rd;
        logic [3:0]   rt, re;
        logic         rdec;
        logic [127:0] bd, bt;

        repeat (2) step();
        check("rst_valid", 128'(out_valid), 128'(1'b0));
        check("rst_data", 128'(out_data), 128'(8'h00));
        check("rst_tag", 128'(out_tag), 128'(4'h0));
        check("rst_tag_ok", 128'(tag_ok), 128'(1'b0));
        check("rst_busy", 128'(busy), 128'(1'b0));
        check("rst_overrun", 128'(overrun), 128'(1'b0));
        rst = 1'b1;
        step();

        // Basic encrypt capture, single-cycle valid with ready held high
        out_ready = 1'b1;
        exp_tag   = 4'h0;
        send(8'hA5, 4'h9, 1'b0, -1);
        check("t1_tag_ok", 128'(tag_ok), 128'(1'b1));
        step();
        check("t1_valid_drop", 128'(out_valid), 128'(1'b0));

        // Decrypt tag compare: match then mismatch
        exp_tag = 4'h9;
        send(8'h5A, 4'h9, 1'b1, -1);
        check("t2_ok_match", 128'(tag_ok), 128'(1'b1));
        step();
        exp_tag = 4'h6;
        send(8'h5A, 4'h9, 1'b1, -1);
        check("t2_ok_mismatch", 128'(tag_ok), 128'(1'b0));
        step();

        // Backpressure: hold for 5 cycles, exp_tag changes after sampling are ignored
        out_ready = 1'b0;
        exp_tag   = 4'h9;
        send(8'hC3, 4'h6, 1'b1, -1);
        exp_tag = 4'h6;
        for (int k = 0; k < 5; k++) begin
            step();
            check("t3_valid_held", 128'(out_valid), 128'(1'b1));
            check("t3_data_stable", 128'(out_data), 128'(8'hC3));
            check("t3_tag_stable", 128'(out_tag), 128'(4'h6));
            check("t3_ok_stable", 128'(tag_ok), 128'(1'b0));
        end
        out_ready = 1'b1;
        step();
        check("t3_valid_drop", 128'(out_valid), 128'(1'b0));
        out_ready = 1'b0;

        // Overruns: rise during shift, rise in hold without ready, set beats clear
        send(8'h96, 4'hA, 1'b0, 3);
        check("t4_ovr_shift", 128'(overrun), 128'(1'b1));
        clr_ovr = 1'b1;
        step();
        clr_ovr = 1'b0;
        check("t4_ovr_clear", 128'(overrun), 128'(1'b0));
        core_ready = 1'b1;
        step();
        check("t4_ovr_hold", 128'(overrun), 128'(1'b1));
        check("t4_valid_kept", 128'(out_valid), 128'(1'b1));
        check("t4_data_intact", 128'(out_data), 128'(8'h96));
        check("t4_tag_intact", 128'(out_tag), 128'(4'hA));
        core_ready = 1'b0;
        step();
        clr_ovr = 1'b1;
        step();
        check("t4_ovr_clear2", 128'(overrun), 128'(1'b0));
        core_ready = 1'b1;
        step();
        check("t4_set_wins", 128'(overrun), 128'(1'b1));
        core_ready = 1'b0;
        step();
        step();
        clr_ovr = 1'b0;
        check("t4_ovr_clear3", 128'(overrun), 128'(1'b0));

        // Handshake and rise in the same cycle: back-to-back capture, no overrun
        out_ready = 1'b1;
        send(8'h3C, 4'h5, 1'b0, -1);
        check("t5_no_ovr", 128'(overrun), 128'(1'b0));
        step();
        check("t5_valid_drop", 128'(out_valid), 128'(1'b0));

        // Reset mid-capture, then a clean capture
        rd = 8'h81;
        for (int i = 0; i < 4; i++) begin
            core_ready = 1'b1;
            ser_data   = rd[7-i];
            ser_tag    = 1'b1;
            step();
        end
        rst = 1'b0;
        #1;
        check("t6_rst_data", 128'(out_data), 128'(8'h00));
        check("t6_rst_tag", 128'(out_tag), 128'(4'h0));
        check("t6_rst_busy", 128'(busy), 128'(1'b0));
        check("t6_rst_valid", 128'(out_valid), 128'(1'b0));
        core_ready = 1'b0;
        step();
        rst = 1'b1;
        step();
        exp_tag = 4'hF;
        send(8'hFF, 4'hF, 1'b1, -1);
        check("t6_ok", 128'(tag_ok), 128'(1'b1));
        step();

        // Randomized words against the reference rule
        for (int r = 0; r < 10; r++) begin
            rd      = 8'($urandom);
            rt      = 4'($urandom);
            rdec    = 1'($urandom);
            re      = ($urandom_range(0, 1) == 0) ? rt : 4'($urandom);
            exp_tag = re;
            send(rd, rt, rdec, -1);
            check("rand_tag_ok", 128'(tag_ok), 128'(model_ok(rdec, rt, re)));
            step();
            check("rand_valid_drop", 128'(out_valid), 128'(1'b0));
        end

        // Full-width instance: latency 128
        bd          = {$urandom, $urandom, $urandom, $urandom};
        bt          = {$urandom, $urandom, $urandom, $urandom};
        b_decrypt   = 1'b1;
        b_exp_tag   = bt;
        b_out_ready = 1'b1;
        for (int i = 0; i < 128; i++) begin
            b_core_ready = 1'b1;
            b_ser_data   = bd[127-i];
            b_ser_tag    = bt[127-i];
            step();
            if (i < 127) check("w_valid_low", 128'(b_out_valid), 128'(1'b0));
        end
        b_core_ready = 1'b0;
        check("w_valid_128", 128'(b_out_valid), 128'(1'b1));
        check("w_data", b_out_data, bd);
        check("w_tag", b_out_tag, bt);
        check("w_tag_ok", 128'(b_tag_ok), 128'(1'b1));
        step();
        check("w_valid_drop", 128'(b_out_valid), 128'(1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
